// File: rtl/recovery_if.sv
// recovery_if: back-end recovery requests, front-end refetch and pipeline phase controls
interface recovery_if #(
  parameter int NUM_REQ  = 4,
  parameter int AL_IDX_W = 6,
  parameter int PC_W     = 32
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*AL_IDX_W-1:0] req_al_ptr;
  logic [NUM_REQ*3-1:0]        req_type;
  logic [NUM_REQ*PC_W-1:0]     req_pc;
  logic [AL_IDX_W-1:0]         al_head;
  logic [PC_W-1:0]             csr_target;
  logic                        walk_done;
  logic [1:0]                  phase;
  logic [NUM_REQ-1:0]          req_ack;
  logic                        refetch_valid;
  logic [PC_W-1:0]             refetch_pc;
  logic [AL_IDX_W-1:0]         recover_al_ptr;
  logic                        flush_front;
  logic                        flush_back;
  logic                        stall_commit;
  modport master (
    output req_valid, req_al_ptr, req_type, req_pc, al_head, csr_target, walk_done,
    input  phase, req_ack, refetch_valid, refetch_pc, recover_al_ptr, flush_front, flush_back, stall_commit
  );
  modport slave (
    input  req_valid, req_al_ptr, req_type, req_pc, al_head, csr_target, walk_done,
    output phase, req_ack, refetch_valid, refetch_pc, recover_al_ptr, flush_front, flush_back, stall_commit
  );
endinterface

// File: rtl/recovery_sequencer.sv
// recovery_sequencer: picks the oldest refetch request and runs COMMIT -> RECOVER_0 -> RECOVER_1 -> COMMIT.
// Define RSD_RECOVERY_PREEMPT_EN to let a strictly older request restart an ongoing recovery.
module recovery_sequencer #(
  parameter int NUM_REQ  = 4,
  parameter int AL_IDX_W = 6,
  parameter int PC_W     = 32
) (
  input logic       clk,
  input logic       rst,
  recovery_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {COMMIT = 2'd0, RECOVER_0 = 2'd1, RECOVER_1 = 2'd2} state_t;
  state_t st;
  logic [AL_IDX_W-1:0] age [NUM_REQ];
  logic [AL_IDX_W-1:0] win_age, win_ptr;
  logic [IW-1:0]       win;
  logic                any, take, preempt;
  logic [2:0]          win_type;
  logic [PC_W-1:0]     win_raw_pc, win_pc;
  // Strict less-than keeps the lowest port on equal age.
  always_comb begin
    any = 1'b0;
    win = '0;
    win_age = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age[i] = bus.req_al_ptr[i*AL_IDX_W +: AL_IDX_W] - bus.al_head;
      if (bus.req_valid[i] && bus.req_type[i*3 +: 3] < 3'd6 && (!any || age[i] < win_age)) begin
        any = 1'b1;
        win = IW'(i);
        win_age = age[i];
      end
    end
  end
  assign win_ptr    = bus.req_al_ptr[win*AL_IDX_W +: AL_IDX_W];
  assign win_type   = bus.req_type[win*3 +: 3];
  assign win_raw_pc = bus.req_pc[win*PC_W +: PC_W];
  assign win_pc     = (win_type == 3'd1 || win_type == 3'd2) ? win_raw_pc + PC_W'(4) :
                      (win_type >= 3'd4) ? bus.csr_target : win_raw_pc;
`ifdef RSD_RECOVERY_PREEMPT_EN
  logic [AL_IDX_W-1:0] cur_age;
  assign cur_age = bus.recover_al_ptr - bus.al_head;
  assign preempt = any && st != COMMIT && win_age < cur_age;
`else
  assign preempt = 1'b0;
`endif
  assign take = (any && st == COMMIT) || preempt;
  assign bus.phase = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st                 <= COMMIT;
      bus.req_ack        <= '0;
      bus.refetch_valid  <= 1'b0;
      bus.refetch_pc     <= '0;
      bus.recover_al_ptr <= '0;
      bus.flush_front    <= 1'b0;
      bus.flush_back     <= 1'b0;
      bus.stall_commit   <= 1'b0;
    end else if (take) begin
      st                 <= RECOVER_0;
      bus.req_ack        <= NUM_REQ'(1) << win;
      bus.refetch_valid  <= 1'b1;
      bus.refetch_pc     <= win_pc;
      bus.recover_al_ptr <= win_ptr;
      bus.flush_front    <= 1'b1;
      bus.flush_back     <= 1'b1;
      bus.stall_commit   <= 1'b1;
    end else begin
      st                 <= st == RECOVER_0 ? RECOVER_1 :
                            (st == RECOVER_1 && !bus.walk_done) ? RECOVER_1 : COMMIT;
      bus.req_ack        <= '0;
      bus.refetch_valid  <= 1'b0;
      bus.flush_front    <= 1'b0;
      bus.flush_back     <= 1'b0;
      bus.stall_commit   <= st == RECOVER_0 || (st == RECOVER_1 && !bus.walk_done);
    end
  end
endmodule

// File: tb/tb_recovery_sequencer.sv
// tb_recovery_sequencer: vector table for accept cases plus hand-written multi-cycle sequences
module tb_recovery_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  recovery_if #(.NUM_REQ(4), .AL_IDX_W(6), .PC_W(32)) bus();
  recovery_sequencer #(.NUM_REQ(4), .AL_IDX_W(6), .PC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0]   v;
    logic [23:0]  ptr;
    logic [11:0]  typ;
    logic [127:0] pc;
    logic [5:0]   head;
    logic [31:0]  csr;
    logic         acc;
    logic [3:0]   ack;
    logic [31:0]  rpc;
    logic [5:0]   rptr;
  } vec_t;
  vec_t vec [7];
  int checks = 0;
  int errors = 0;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(vec_t t);
    bus.req_valid  = t.v;
    bus.req_al_ptr = t.ptr;
    bus.req_type   = t.typ;
    bus.req_pc     = t.pc;
    bus.al_head    = t.head;
    bus.csr_target = t.csr;
  endtask
  task automatic set_port(int p, logic [5:0] ptr, logic [2:0] typ, logic [31:0] pc);
    bus.req_valid[p] = 1'b1;
    bus.req_al_ptr[p*6 +: 6] = ptr;
    bus.req_type[p*3 +: 3] = typ;
    bus.req_pc[p*32 +: 32] = pc;
  endtask
  task automatic check_idle(string nm);
    check({nm, " phase"}, 32'(bus.phase), 0);
    check({nm, " ack"}, 32'(bus.req_ack), 0);
    check({nm, " refetch_valid"}, 32'(bus.refetch_valid), 0);
    check({nm, " stall"}, 32'(bus.stall_commit), 0);
    check({nm, " flush_front"}, 32'(bus.flush_front), 0);
    check({nm, " flush_back"}, 32'(bus.flush_back), 0);
  endtask
  task automatic check_r0(string nm, logic [3:0] ack, logic [31:0] rpc, logic [5:0] rptr);
    check({nm, " r0 phase"}, 32'(bus.phase), 1);
    check({nm, " r0 ack"}, 32'(bus.req_ack), 32'(ack));
    check({nm, " r0 refetch_valid"}, 32'(bus.refetch_valid), 1);
    check({nm, " r0 refetch_pc"}, bus.refetch_pc, rpc);
    check({nm, " r0 al_ptr"}, 32'(bus.recover_al_ptr), 32'(rptr));
    check({nm, " r0 flush_front"}, 32'(bus.flush_front), 1);
    check({nm, " r0 flush_back"}, 32'(bus.flush_back), 1);
    check({nm, " r0 stall"}, 32'(bus.stall_commit), 1);
  endtask
  task automatic check_r1(string nm);
    check({nm, " r1 phase"}, 32'(bus.phase), 2);
    check({nm, " r1 stall"}, 32'(bus.stall_commit), 1);
    check({nm, " r1 ack"}, 32'(bus.req_ack), 0);
    check({nm, " r1 refetch_valid"}, 32'(bus.refetch_valid), 0);
    check({nm, " r1 flush_front"}, 32'(bus.flush_front), 0);
  endtask
  initial begin
    vec[0] = '{v:4'b0010, ptr:{6'd0, 6'd0, 6'd7, 6'd0}, typ:{3'd0, 3'd0, 3'd1, 3'd0},
               pc:{32'h0, 32'h0, 32'h1000, 32'h0}, head:6'd0, csr:32'h0,
               acc:1'b1, ack:4'b0010, rpc:32'h1004, rptr:6'd7};
    vec[1] = '{v:4'b1001, ptr:{6'd62, 6'd0, 6'd0, 6'd2}, typ:{3'd0, 3'd0, 3'd0, 3'd0},
               pc:{32'h3000, 32'h0, 32'h0, 32'h100}, head:6'd60, csr:32'h0,
               acc:1'b1, ack:4'b1000, rpc:32'h3000, rptr:6'd62};
    vec[2] = '{v:4'b0101, ptr:{6'd0, 6'd5, 6'd0, 6'd5}, typ:{3'd0, 3'd5, 3'd0, 3'd5},
               pc:{32'h0, 32'h44, 32'h0, 32'h88}, head:6'd0, csr:32'h200,
               acc:1'b1, ack:4'b0001, rpc:32'h200, rptr:6'd5};
    vec[3] = '{v:4'b0001, ptr:{6'd0, 6'd0, 6'd0, 6'd9}, typ:{3'd0, 3'd0, 3'd0, 3'd2},
               pc:{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC}, head:6'd0, csr:32'h0,
               acc:1'b1, ack:4'b0001, rpc:32'h0, rptr:6'd9};
    vec[4] = '{v:4'b0100, ptr:{6'd0, 6'd3, 6'd0, 6'd0}, typ:{3'd0, 3'd7, 3'd0, 3'd0},
               pc:{32'h0, 32'h1234, 32'h0, 32'h0}, head:6'd0, csr:32'h0,
               acc:1'b0, ack:4'b0000, rpc:32'h0, rptr:6'd0};
    vec[5] = '{v:4'b0011, ptr:{6'd0, 6'd0, 6'd20, 6'd1}, typ:{3'd0, 3'd0, 3'd3, 3'd6},
               pc:{32'h0, 32'h0, 32'hABC0, 32'h50}, head:6'd0, csr:32'h0,
               acc:1'b1, ack:4'b0010, rpc:32'hABC0, rptr:6'd20};
    vec[6] = '{v:4'b1000, ptr:{6'd33, 6'd0, 6'd0, 6'd0}, typ:{3'd4, 3'd0, 3'd0, 3'd0},
               pc:{32'h700, 32'h0, 32'h0, 32'h0}, head:6'd30, csr:32'h8000_0000,
               acc:1'b1, ack:4'b1000, rpc:32'h8000_0000, rptr:6'd33};
    bus.req_valid = '0; bus.req_al_ptr = '0; bus.req_type = '0; bus.req_pc = '0;
    bus.al_head = '0; bus.csr_target = '0; bus.walk_done = 1'b1;
    tick(); tick();
    check_idle("reset");
    check("reset refetch_pc", bus.refetch_pc, 0);
    check("reset al_ptr", 32'(bus.recover_al_ptr), 0);
    rst = 1'b0;
    tick();
    check_idle("idle");
    // Table: accept in COMMIT, minimum three-cycle recovery with walk_done held high.
    for (int k = 0; k < 7; k++) begin
      drive(vec[k]);
      tick();
      if (vec[k].acc) begin
        check_r0($sformatf("vec%0d", k), vec[k].ack, vec[k].rpc, vec[k].rptr);
        bus.req_valid = '0;
        tick();
        check_r1($sformatf("vec%0d", k));
        tick();
        check($sformatf("vec%0d back phase", k), 32'(bus.phase), 0);
        check($sformatf("vec%0d back stall", k), 32'(bus.stall_commit), 0);
      end else begin
        check_idle($sformatf("vec%0d none", k));
        bus.req_valid = '0;
      end
    end
    // Walk handshake: RECOVER_1 holds while walk_done is low.
    bus.walk_done = 1'b0; bus.al_head = '0;
    set_port(2, 6'd12, 3'd0, 32'h900);
    tick();
    check_r0("walk", 4'b0100, 32'h900, 6'd12);
    bus.req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_r1($sformatf("walk hold%0d", c));
    end
    bus.walk_done = 1'b1;
    tick();
    check_idle("walk done");
    // Non-winning request stays pending and is taken after COMMIT returns.
    set_port(1, 6'd3, 3'd0, 32'h10);
    set_port(3, 6'd8, 3'd0, 32'h20);
    tick();
    check_r0("pend first", 4'b0010, 32'h10, 6'd3);
    bus.req_valid[1] = 1'b0;
    tick();
    check_r1("pend");
    tick();
    check("pend commit phase", 32'(bus.phase), 0);
    tick();
    check_r0("pend second", 4'b1000, 32'h20, 6'd8);
    bus.req_valid = '0;
    tick(); tick();
    check("pend end phase", 32'(bus.phase), 0);
    // Preemption by a strictly older request during RECOVER_1.
    bus.walk_done = 1'b0;
    set_port(0, 6'd10, 3'd0, 32'h400);
    tick();
    check_r0("pre first", 4'b0001, 32'h400, 6'd10);
    bus.req_valid = '0;
    tick();
    check_r1("pre");
    set_port(2, 6'd4, 3'd0, 32'h500);
`ifdef RSD_RECOVERY_PREEMPT_EN
    tick();
    check_r0("pre hit", 4'b0100, 32'h500, 6'd4);
    bus.req_valid = '0;
    bus.walk_done = 1'b1;
    tick();
    check_r1("pre after");
    tick();
    check("pre end phase", 32'(bus.phase), 0);
`else
    bus.walk_done = 1'b1;
    tick();
    check_idle("pre ignored");
    tick();
    check_r0("pre later", 4'b0100, 32'h500, 6'd4);
    bus.req_valid = '0;
    tick(); tick();
    check("pre end phase", 32'(bus.phase), 0);
`endif
    // Reset in RECOVER_1 discards latched state.
    bus.walk_done = 1'b0;
    set_port(3, 6'd17, 3'd1, 32'hC00);
    tick();
    check_r0("rst", 4'b1000, 32'hC04, 6'd17);
    bus.req_valid = '0;
    tick();
    check_r1("rst");
    rst = 1'b1;
    tick();
    check_idle("rst mid");
    check("rst mid refetch_pc", bus.refetch_pc, 0);
    check("rst mid al_ptr", 32'(bus.recover_al_ptr), 0);
    rst = 1'b0;
    bus.walk_done = 1'b1;
    tick();
    check_idle("rst after");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
